// File: rtl/half_pkg.sv
// Shared types and helpers for the half-precision streaming blocks.
// Pure definitions; no latency and no flow control.
package half_pkg;

  typedef logic [15:0] half_t;

  // Index width for a dimension; a size of 1 still needs a 1-bit counter.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/half_idx_counter.sv
// 2-D nested index counter: the inner index runs fastest, and wrap flags the final count.
// Advances once per cycle that i_en is high; the indices are registered and stay put otherwise.
module half_idx_counter
  import half_pkg::*;
#(
  parameter int OUTER = 1,
  parameter int INNER = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_en,
  output logic [clog2_min1(OUTER)-1:0]  o_outer_idx,
  output logic [clog2_min1(INNER)-1:0]  o_inner_idx,
  output logic                          o_wrap
);

  localparam int OW = clog2_min1(OUTER);
  localparam int IW = clog2_min1(INNER);
  localparam logic [OW-1:0] OUTER_LAST = OW'(OUTER - 1);
  localparam logic [IW-1:0] INNER_LAST = IW'(INNER - 1);

  logic [OW-1:0] r_outer;
  logic [IW-1:0] r_inner;
  logic          w_outer_last;
  logic          w_inner_last;

  assign w_outer_last = (r_outer == OUTER_LAST);
  assign w_inner_last = (r_inner == INNER_LAST);

  assign o_outer_idx = r_outer;
  assign o_inner_idx = r_inner;
  assign o_wrap      = w_outer_last && w_inner_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outer <= '0;
      r_inner <= '0;
    end else if (i_en) begin
      if (w_inner_last) begin
        r_inner <= '0;
        r_outer <= w_outer_last ? '0 : r_outer + 1'b1;
      end else begin
        r_inner <= r_inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/half_transpose_stream.sv
// Ping-pong streaming transpose: WIDTH x HEIGHT in, HEIGHT x WIDTH out. First output comes 1 cycle after the last input.
// in_ready drops only while both banks are full; out_data and out_last hold while out_ready is low.
module half_transpose_stream
  import half_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int HEIGHT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        err
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = clog2_min1(DEPTH);
  localparam int WW    = clog2_min1(WIDTH);
  localparam int HW    = clog2_min1(HEIGHT);

  half_t         r_bank [2][DEPTH];
  logic [1:0]    r_full;
  logic          r_wb;
  logic          r_rb;
  logic          r_err;

  logic          w_in_fire;
  logic          w_out_fire;
  logic [WW-1:0] w_wi;
  logic [HW-1:0] w_wj;
  logic          w_wwrap;
  logic [WW-1:0] w_ri;
  logic [HW-1:0] w_rj;
  logic          w_rwrap;
  logic [AW-1:0] w_waddr;
  logic [AW-1:0] w_raddr;

  assign in_ready   = !r_full[r_wb];
  assign out_valid  = r_full[r_rb];
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  // Write side walks row-major over the input (j fastest).
  half_idx_counter #(
    .OUTER (WIDTH),
    .INNER (HEIGHT)
  ) u_wr_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_in_fire),
    .o_outer_idx (w_wi),
    .o_inner_idx (w_wj),
    .o_wrap      (w_wwrap)
  );

  // Read side swaps the loop nesting (i fastest), which is the transpose.
  half_idx_counter #(
    .OUTER (HEIGHT),
    .INNER (WIDTH)
  ) u_rd_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_out_fire),
    .o_outer_idx (w_rj),
    .o_inner_idx (w_ri),
    .o_wrap      (w_rwrap)
  );

  assign w_waddr = AW'(w_wi) * AW'(HEIGHT) + AW'(w_wj);
  assign w_raddr = AW'(w_ri) * AW'(HEIGHT) + AW'(w_rj);

  assign out_data = r_bank[r_rb][w_raddr];
  assign out_last = out_valid && w_rwrap;
  assign err      = r_err;

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_bank[r_wb][w_waddr] <= in_data;
    end
  end

  // A write completion and a read completion always target different banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= '0;
      r_wb   <= 1'b0;
      r_rb   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_in_fire && w_wwrap) begin
        r_full[r_wb] <= 1'b1;
        r_wb         <= ~r_wb;
      end
      if (w_out_fire && w_rwrap) begin
        r_full[r_rb] <= 1'b0;
        r_rb         <= ~r_rb;
      end
      if (w_in_fire && (in_last != w_wwrap)) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/half_transpose_stream.md
Name: half_transpose_stream

Overview:
- Streaming matrix transpose for half-precision (16-bit) data.
- Accepts a WIDTH x HEIGHT matrix one element per cycle in input order, and emits its HEIGHT x WIDTH transpose one element per cycle.
- Uses two ping-pong banks, so one matrix can load while the previous one drains.
- Sits between the half-precision layer engines and any consumer that needs a transposed operand, for example a weight-gradient path.

Parameters:
- WIDTH, 10, outer dimension of the input matrix m_in[WIDTH][HEIGHT].
- HEIGHT, 10, inner dimension of the input matrix. The output is m_out[HEIGHT][WIDTH].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  16  half-precision element.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an element.
- in_last  input  1  asserted with the final element of an input matrix.
- out_data  output  16  transposed element.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.
- out_last  output  1  asserted with the final element of an output matrix.
- err  output  1  sticky in_last framing error.

Behaviour:
- Transfer rule: a transfer occurs on any edge where valid and ready are both high. in_data must hold while in_valid=1 and in_ready=0. The block holds out_data and out_last while out_valid=1 and out_ready=0.
- Input order: m_in[i][j], with j (0..HEIGHT-1) fastest and i (0..WIDTH-1) slowest. Element (i,j) is written to bank[wb] at address i*HEIGHT+j.
- Output order: m_out[j][i], with i fastest and j slowest. The element presented is bank[rb][i*HEIGHT+j].
- Storage: two banks of WIDTH*HEIGHT x 16 flops. Each bank has a full flag. wb and rb are 1-bit bank selectors.
- Write side: in_ready = !full[wb].
  - Each transfer advances the write counters (wj, then wi).
  - On the transfer at (WIDTH-1, HEIGHT-1): full[wb] is set, wb toggles, and both counters wrap to 0.
- Read side: out_valid = full[rb]. out_data is read combinationally from bank[rb] at the current (ri, rj).
  - out_last = out_valid && ri==WIDTH-1 && rj==HEIGHT-1.
  - Each transfer advances ri, then rj.
  - On the final transfer: full[rb] is cleared, rb toggles, and both counters wrap to 0.
- Latency: the first output element is valid on the cycle after the last input element is accepted.
- Throughput: with the source and consumer never stalling, sustained rate is 1 element/cycle after the initial WIDTH*HEIGHT-cycle fill.
- Simultaneous events: a bank may complete its write on the same edge that the other bank completes its read. Both flag updates take effect.
  - A read completion on bank X and a write start on bank X cannot coincide, because in_ready for X only rises the cycle after its full flag clears.
- Both banks full: in_ready=0. Input stalls indefinitely without data loss.
- Framing: matrix boundaries are set by the counters only.
  - err is set on the edge of any transfer where in_last=1 at a non-final element, or in_last=0 at the final element.
  - err stays set until rst. Data flow is unaffected.
- Reset (asserted at any time, including mid-matrix): on the clocked edge,
  - wb, rb and all counters are 0, and both full flags are 0;
  - err=0, out_valid=0, out_last=0, in_ready=1 on the following cycle.
  - Partial bank contents are discarded. Bank data is not reset.
- Parameter limits: WIDTH>=1 and HEIGHT>=1. WIDTH=HEIGHT=1 is a legal 1-element pass-through with 1-cycle latency.
- Counter widths: $clog2 of the dimension, minimum 1 bit.

Decomposition:
- Shared package half_pkg:
  - typedef half_t (logic [15:0]).
  - function clog2_min1.
- Sub-module half_idx_counter:
  - 2-D nested counter with parameters OUTER and INNER, and an enable input.
  - Outputs outer_idx, inner_idx, and wrap (high on the final count).
  - Instantiated twice: write side (outer=WIDTH, inner=HEIGHT) and read side (outer=HEIGHT, inner=WIDTH).

Test Plan:
- WIDTH=3, HEIGHT=2, no stalls: input 0x0000..0x0005 with in_last on 0x0005 -> output 0x0000, 0x0002, 0x0004, 0x0001, 0x0003, 0x0005, with out_last only on 0x0005. First out_valid appears 1 cycle after the 0x0005 transfer. err=0.
- Back-to-back matrices, out_ready=1, defaults 10x10: 3 matrices fed continuously (0x3C00+k) -> in_ready never drops after the first fill. All 300 outputs are correctly transposed, with no gaps after the first output.
- Backpressure, 3x2: out_ready=0 while 2 matrices are loaded -> in_ready=0 once both banks are full. The third matrix stalls. Releasing out_ready drains the matrices in order with out_data held stable during stalls.
- Framing error, 3x2: in_last on the 3rd element -> err=1 from the next cycle. Output ordering is still correct for the 6-element matrix. err persists after the matrix drains.
- Reset mid-operation: rst after 4 of 6 inputs -> next cycle out_valid=0 and in_ready=1. A following complete matrix 0x0010..0x0015 outputs 0x0010, 0x0012, 0x0014, 0x0011, 0x0013, 0x0015.
- WIDTH=HEIGHT=1: stream 0xABCD, 0x1234 -> outputs in order, each with out_last=1. Randomised valid/ready with a scoreboard shows no loss or duplication.
